// File: rtl/xentry_pkg.sv
// Shared LSU request encodings for the data-cache datapaths.
package xentry_pkg;

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

endpackage

// File: rtl/dcache_lru_tracker.sv
// True-LRU age tracker: one age per way per set, age NUM_WAYS-1 is the victim.
module dcache_lru_tracker #(
    parameter  int unsigned NUM_SETS = 16,
    parameter  int unsigned NUM_WAYS = 2,
    localparam int unsigned SETW     = $clog2(NUM_SETS),
    localparam int unsigned WAYW     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            touch_i,
    input  logic [SETW-1:0] touch_set_i,
    input  logic [WAYW-1:0] touch_way_i,
    input  logic [SETW-1:0] query_set_i,
    output logic [WAYW-1:0] victim_way_o
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAYW-1:0] age_q;

    // Ages younger than the touched way grow older; the touched way becomes MRU.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAYW'(w);
                end
            end
        end else if (touch_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAYW'(w) == touch_way_i) begin
                    age_q[touch_set_i][w] <= '0;
                end else if (age_q[touch_set_i][w] < age_q[touch_set_i][touch_way_i]) begin
                    age_q[touch_set_i][w] <= age_q[touch_set_i][w] + WAYW'(1);
                end
            end
        end
    end

    // Oldest way of the queried set.
    always_comb begin
        victim_way_o = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[query_set_i][w] == WAYW'(NUM_WAYS - 1)) begin
                victim_way_o = WAYW'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_assoc_datapath.sv
// Set-associative dcache datapath: lookup, victim choice, serial fill/write-back, store merge.
module dcache_assoc_datapath
    import xentry_pkg::*;
#(
    parameter  int unsigned LINE_SIZE = 32,
    parameter  int unsigned NUM_SETS  = 16,
    parameter  int unsigned NUM_WAYS  = 2,
    parameter  int unsigned XLEN      = 32,
    localparam int unsigned BPW       = XLEN / 8,
    localparam int unsigned WPL       = LINE_SIZE / BPW,
    localparam int unsigned OFS       = $clog2(LINE_SIZE),
    localparam int unsigned SETW      = $clog2(NUM_SETS),
    localparam int unsigned TAGW      = XLEN - OFS - SETW,
    localparam int unsigned WAYW      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int unsigned BOFS      = $clog2(BPW),
    localparam int unsigned CNTW      = (WPL > 1) ? $clog2(WPL) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        pipe_req_addr,
    input  memory_operation_size_e pipe_req_size,
    input  memory_operation_e      pipe_req_type,
    input  logic                   pipe_req_valid,
    input  logic [XLEN-1:0]        pipe_word_to_store,
    output logic [XLEN-1:0]        pipe_fetched_word,
    output logic                   pipe_fetched_word_valid,
    output logic [XLEN-1:0]        l2_req_address,
    input  logic [XLEN-1:0]        l2_fetched_word,
    output logic [XLEN-1:0]        l2_word_to_store,
    input  logic                   flush_mode,
    input  logic                   load_mode,
    input  logic                   clear_victim_dirty,
    input  logic                   clear_victim_valid,
    input  logic                   finish_new_line_install,
    input  logic                   set_new_l2_block_address,
    input  logic                   reset_counter,
    input  logic                   decrement_counter,
    output logic                   counter_done,
    output logic                   hit,
    output logic                   clean_miss,
    output logic                   dirty_miss
);

    logic [TAGW-1:0]                     tag_q  [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]                     data_q [NUM_SETS][NUM_WAYS][WPL];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   dirty_q;
    logic [CNTW-1:0]                     counter_q;
    logic [WAYW-1:0]                     victim_way_q;
    logic [TAGW+SETW-1:0]                l2_block_addr_q;

    logic [TAGW-1:0]     req_tag;
    logic [SETW-1:0]     req_set;
    logic [CNTW-1:0]     req_word;
    logic [BOFS-1:0]     byte_off;
    logic [BOFS-1:0]     aligned_off;
    logic [BOFS+2:0]     lane_shift;
    logic [XLEN-1:0]     size_mask;
    logic [XLEN-1:0]     lane_mask;
    logic [XLEN-1:0]     hit_word;
    logic [XLEN-1:0]     merged_word;
    logic [NUM_WAYS-1:0] match_vec;
    logic [WAYW-1:0]     hit_way;
    logic [WAYW-1:0]     victim_way;
    logic [WAYW-1:0]     lru_victim;
    logic                hit_any;
    logic                victim_dirty;
    logic                store_write;
    logic                lru_touch;
    logic [WAYW-1:0]     lru_touch_way;

    assign req_tag  = pipe_req_addr[XLEN-1 -: TAGW];
    assign req_set  = pipe_req_addr[OFS +: SETW];
    assign req_word = CNTW'((pipe_req_addr >> BOFS) & XLEN'(WPL - 1));
    assign byte_off = pipe_req_addr[BOFS-1:0];

    // Tag lookup across all ways of the request set.
    always_comb begin
        match_vec = '0;
        hit_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                match_vec[w] = 1'b1;
                hit_way      = WAYW'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the LRU way.
    always_comb begin
        victim_way = lru_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                victim_way = WAYW'(w);
            end
        end
    end

    assign hit_any      = |match_vec;
    assign victim_dirty = valid_q[req_set][victim_way] & dirty_q[req_set][victim_way];
    assign hit          = pipe_req_valid & hit_any;
    assign clean_miss   = pipe_req_valid & ~hit_any & ~victim_dirty;
    assign dirty_miss   = pipe_req_valid & ~hit_any & victim_dirty;
    assign store_write  = hit & (pipe_req_type == STORE) & ~load_mode & ~flush_mode;

    // Byte-lane selection; misaligned offsets are truncated to the access size.
    always_comb begin
        aligned_off = byte_off;
        size_mask   = XLEN'(32'hFFFF_FFFF);
        case (pipe_req_size)
            BYTE: begin
                aligned_off = byte_off;
                size_mask   = XLEN'(8'hFF);
            end
            HALF: begin
                aligned_off = byte_off & ~BOFS'(1);
                size_mask   = XLEN'(16'hFFFF);
            end
            default: begin
                aligned_off = byte_off & ~BOFS'(3);
                size_mask   = XLEN'(32'hFFFF_FFFF);
            end
        endcase
    end

    assign lane_shift  = {aligned_off, 3'b000};
    assign lane_mask   = size_mask << lane_shift;
    assign hit_word    = data_q[req_set][hit_way][req_word];
    assign merged_word = (hit_word & ~lane_mask) | ((pipe_word_to_store << lane_shift) & lane_mask);

    assign pipe_fetched_word       = hit ? ((hit_word >> lane_shift) & size_mask) : '0;
    assign pipe_fetched_word_valid = hit;
    assign l2_word_to_store        = data_q[req_set][victim_way_q][counter_q];
    assign l2_req_address          = {l2_block_addr_q, OFS'(OFS'(counter_q) << BOFS)};
    assign counter_done            = (counter_q == '0);

    // Word counter, latched victim way and L2 block address.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q       <= CNTW'(WPL - 1);
            victim_way_q    <= '0;
            l2_block_addr_q <= '0;
        end else begin
            if (reset_counter) begin
                counter_q <= CNTW'(WPL - 1);
            end else if (decrement_counter) begin
                counter_q <= (counter_q == '0) ? CNTW'(WPL - 1) : counter_q - CNTW'(1);
            end
            if (set_new_l2_block_address) begin
                victim_way_q    <= victim_way;
                l2_block_addr_q <= dirty_miss ? {tag_q[req_set][victim_way], req_set}
                                              : {req_tag, req_set};
            end
        end
    end

    // Valid/dirty bits; clears are written last so they win over sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (finish_new_line_install) valid_q[req_set][victim_way_q] <= 1'b1;
            if (clear_victim_valid)      valid_q[req_set][victim_way_q] <= 1'b0;
            if (store_write)             dirty_q[req_set][hit_way]      <= 1'b1;
            if (clear_victim_dirty)      dirty_q[req_set][victim_way_q] <= 1'b0;
        end
    end

    // Tag and data arrays: fill words into the victim, merged stores into the hit way.
    always_ff @(posedge clk) begin
        if (finish_new_line_install) begin
            tag_q[req_set][victim_way_q] <= req_tag;
        end
        if (load_mode) begin
            data_q[req_set][victim_way_q][counter_q] <= l2_fetched_word;
        end else if (store_write) begin
            data_q[req_set][hit_way][req_word] <= merged_word;
        end
    end

    assign lru_touch     = finish_new_line_install | hit;
    assign lru_touch_way = finish_new_line_install ? victim_way_q : hit_way;

    dcache_lru_tracker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk          (clk),
        .reset        (reset),
        .touch_i      (lru_touch),
        .touch_set_i  (req_set),
        .touch_way_i  (lru_touch_way),
        .query_set_i  (req_set),
        .victim_way_o (lru_victim)
    );

    hit_way_unique: assert property (@(posedge clk) disable iff (reset) $onehot0(match_vec));
    modes_exclusive: assert property (@(posedge clk) disable iff (reset) !(flush_mode && load_mode));

endmodule

// File: tb/tb_dcache_assoc_datapath.sv
// Directed bench for dcache_assoc_datapath (4 sets, 2 ways, 16-byte lines, 32-bit).
module tb_dcache_assoc_datapath;
    import xentry_pkg::*;

    logic                   clk;
    logic                   reset;
    logic [31:0]            pipe_req_addr;
    memory_operation_size_e pipe_req_size;
    memory_operation_e      pipe_req_type;
    logic                   pipe_req_valid;
    logic [31:0]            pipe_word_to_store;
    logic [31:0]            pipe_fetched_word;
    logic                   pipe_fetched_word_valid;
    logic [31:0]            l2_req_address;
    logic [31:0]            l2_fetched_word;
    logic [31:0]            l2_word_to_store;
    logic                   flush_mode, load_mode;
    logic                   clear_victim_dirty, clear_victim_valid;
    logic                   finish_new_line_install, set_new_l2_block_address;
    logic                   reset_counter, decrement_counter;
    logic                   counter_done;
    logic                   hit, clean_miss, dirty_miss;

    int checks = 0;
    int errors = 0;

    dcache_assoc_datapath #(
        .LINE_SIZE (16),
        .NUM_SETS  (4),
        .NUM_WAYS  (2),
        .XLEN      (32)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .pipe_req_addr            (pipe_req_addr),
        .pipe_req_size            (pipe_req_size),
        .pipe_req_type            (pipe_req_type),
        .pipe_req_valid           (pipe_req_valid),
        .pipe_word_to_store       (pipe_word_to_store),
        .pipe_fetched_word        (pipe_fetched_word),
        .pipe_fetched_word_valid  (pipe_fetched_word_valid),
        .l2_req_address           (l2_req_address),
        .l2_fetched_word          (l2_fetched_word),
        .l2_word_to_store         (l2_word_to_store),
        .flush_mode               (flush_mode),
        .load_mode                (load_mode),
        .clear_victim_dirty       (clear_victim_dirty),
        .clear_victim_valid       (clear_victim_valid),
        .finish_new_line_install  (finish_new_line_install),
        .set_new_l2_block_address (set_new_l2_block_address),
        .reset_counter            (reset_counter),
        .decrement_counter        (decrement_counter),
        .counter_done             (counter_done),
        .hit                      (hit),
        .clean_miss               (clean_miss),
        .dirty_miss               (dirty_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'b0, hit, clean_miss, dirty_miss};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input memory_operation_e t, input memory_operation_size_e s,
                       input logic [31:0] a, input logic [31:0] d);
        pipe_req_valid     = 1'b1;
        pipe_req_type      = t;
        pipe_req_size      = s;
        pipe_req_addr      = a;
        pipe_word_to_store = d;
        #1;
    endtask

    // Full line fill into the victim: word 0 gets w0, word c gets base+c.
    task automatic fill(input logic [31:0] w0, input logic [31:0] base);
        set_new_l2_block_address = 1'b1;
        tick();
        set_new_l2_block_address = 1'b0;
        reset_counter = 1'b1;
        tick();
        reset_counter = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            load_mode         = 1'b1;
            decrement_counter = 1'b1;
            l2_fetched_word   = (c == 0) ? w0 : base + 32'(c);
            tick();
        end
        load_mode               = 1'b0;
        decrement_counter       = 1'b0;
        finish_new_line_install = 1'b1;
        tick();
        finish_new_line_install = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pipe_req_addr = '0; pipe_req_size = WORD; pipe_req_type = LOAD;
        pipe_req_valid = 1'b0; pipe_word_to_store = '0; l2_fetched_word = '0;
        flush_mode = 1'b0; load_mode = 1'b0;
        clear_victim_dirty = 1'b0; clear_victim_valid = 1'b0;
        finish_new_line_install = 1'b0; set_new_l2_block_address = 1'b0;
        reset_counter = 1'b0; decrement_counter = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_flags", flags(), 32'h0);
        check_eq("rst_l2addr", l2_req_address, 32'h0000_000C);
        check_eq("rst_done", 32'(counter_done), 32'h0);

        // First line: tag 1, set 0
        req(LOAD, WORD, 32'h40, 0);
        check_eq("t1_miss", flags(), 32'h2);
        fill(32'hA0, 32'hA0);
        check_eq("t1_l2addr", l2_req_address, 32'h0000_004C);
        check_eq("t1_hit", flags(), 32'h4);
        check_eq("t1_w0", pipe_fetched_word, 32'hA0);
        req(LOAD, WORD, 32'h4C, 0);
        check_eq("t1_w3", pipe_fetched_word, 32'hA3);

        // Second way: tag 2
        req(LOAD, WORD, 32'h80, 0);
        check_eq("t2_miss", flags(), 32'h2);
        fill(32'hB0, 32'hB0);
        check_eq("t2_l2addr", l2_req_address, 32'h0000_008C);
        req(LOAD, WORD, 32'h84, 0);
        check_eq("t2_w1", pipe_fetched_word, 32'hB1);
        check_eq("t2_hit_valid", 32'(pipe_fetched_word_valid), 32'h1);

        // Touch tag 1 so tag 2 becomes LRU
        req(LOAD, WORD, 32'h40, 0);
        check_eq("touch_t1", flags(), 32'h4);
        tick();

        // Tag 3 must evict tag 2
        req(LOAD, WORD, 32'hC0, 0);
        check_eq("t3_miss", flags(), 32'h2);
        fill(32'h1122_3344, 32'hC0);
        check_eq("t3_l2addr", l2_req_address, 32'h0000_00CC);
        req(LOAD, WORD, 32'h80, 0);
        check_eq("t2_evicted", flags(), 32'h2);
        req(LOAD, WORD, 32'h40, 0);
        check_eq("t1_kept", flags(), 32'h4);

        // Store byte into tag 3 word 0
        req(STORE, BYTE, 32'hC2, 32'h5A);
        check_eq("st_hit", flags(), 32'h4);
        tick();
        req(LOAD, WORD, 32'hC0, 0);
        check_eq("st_word", pipe_fetched_word, 32'h115A_3344);
        req(LOAD, HALF, 32'hC2, 0);
        check_eq("ld_half", pipe_fetched_word, 32'h0000_115A);
        req(LOAD, BYTE, 32'hC1, 0);
        check_eq("ld_byte", pipe_fetched_word, 32'h0000_0033);
        req(LOAD, HALF, 32'hC3, 0);
        check_eq("ld_half_misal", pipe_fetched_word, 32'h0000_115A);

        // Tag 3 is MRU: tag 4 victimises the clean tag-1 way
        req(LOAD, WORD, 32'h100, 0);
        check_eq("lru_t3_mru", flags(), 32'h2);

        // Touch tag 1 so dirty tag 3 becomes the victim
        req(LOAD, WORD, 32'h40, 0);
        tick();
        req(LOAD, WORD, 32'h100, 0);
        check_eq("dirty_miss", flags(), 32'h1);
        set_new_l2_block_address = 1'b1;
        tick();
        set_new_l2_block_address = 1'b0;
        check_eq("wb_l2addr", l2_req_address, 32'h0000_00CC);
        reset_counter = 1'b1;
        tick();
        reset_counter = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            flush_mode        = 1'b1;
            decrement_counter = 1'b1;
            #1;
            check_eq("wb_data", l2_word_to_store, (c == 0) ? 32'h115A_3344 : 32'hC0 + 32'(c));
            check_eq("wb_addr", l2_req_address, 32'hC0 + 32'(c * 4));
            check_eq("wb_done", 32'(counter_done), (c == 0) ? 32'h1 : 32'h0);
            tick();
        end
        flush_mode        = 1'b0;
        decrement_counter = 1'b0;
        check_eq("wb_wrap", l2_req_address, 32'h0000_00CC);
        clear_victim_dirty = 1'b1;
        tick();
        clear_victim_dirty = 1'b0;
        #1;
        check_eq("wb_cleaned", flags(), 32'h2);

        // Clear-valid wins over install
        clear_victim_valid      = 1'b1;
        finish_new_line_install = 1'b1;
        tick();
        clear_victim_valid      = 1'b0;
        finish_new_line_install = 1'b0;
        #1;
        check_eq("clr_vs_inst", flags(), 32'h2);
        req(LOAD, WORD, 32'hC0, 0);
        check_eq("clr_old_gone", flags(), 32'h2);

        // Counter: reset_counter wins over decrement
        decrement_counter = 1'b1;
        tick();
        decrement_counter = 1'b0;
        #1;
        check_eq("cnt_dec", l2_req_address, 32'h0000_00C8);
        reset_counter     = 1'b1;
        decrement_counter = 1'b1;
        tick();
        reset_counter     = 1'b0;
        decrement_counter = 1'b0;
        #1;
        check_eq("cnt_rst_prio", l2_req_address, 32'h0000_00CC);

        // Reset in the middle of a fill
        req(LOAD, WORD, 32'h140, 0);
        set_new_l2_block_address = 1'b1;
        tick();
        set_new_l2_block_address = 1'b0;
        reset_counter = 1'b1;
        tick();
        reset_counter     = 1'b0;
        load_mode         = 1'b1;
        decrement_counter = 1'b1;
        l2_fetched_word   = 32'hDEAD_BEEF;
        tick();
        tick();
        check_eq("mid_fill_cnt", l2_req_address, 32'h0000_0144);
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        load_mode         = 1'b0;
        decrement_counter = 1'b0;
        pipe_req_valid    = 1'b0;
        #1;
        check_eq("mrst_flags", flags(), 32'h0);
        check_eq("mrst_l2addr", l2_req_address, 32'h0000_000C);
        check_eq("mrst_done", 32'(counter_done), 32'h0);
        req(LOAD, WORD, 32'h40, 0);
        check_eq("mrst_t1_miss", flags(), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
